// File: rtl/median_filter_param_pkg.sv
// Shared types and the width-agnostic compare used by the parametrised median filter.
// The compare takes zero-extended operands and biases the sign bit for signed order.
package median_filter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SORT   = 2'd1,
    ST_OUTPUT = 2'd2
  } state_t;

  localparam logic [1:0] RANK_MIN = 2'd0;
  localparam logic [1:0] RANK_MED = 2'd1;
  localparam logic [1:0] RANK_MAX = 2'd2;

  // Flipping bit (width-1) maps two's-complement order onto unsigned order.
  function automatic logic median_le(input logic [31:0] a, input logic [31:0] b,
                                     input logic is_signed, input int width);
    logic [31:0] bias;
    bias = is_signed ? (32'd1 << (width - 1)) : 32'd0;
    return (a ^ bias) <= (b ^ bias);
  endfunction

endpackage

// File: rtl/median_filter_param_if.sv
// Sample/result bundle of the median filter; master drives samples, slave is the filter.
interface median_filter_param_if #(
  parameter int WIDTH = 16
);
  logic             enable;
  logic [WIDTH-1:0] in;
  logic [1:0]       rank_sel;
  logic             clear;
  logic             busy;
  logic             overrun;
  logic             out_enable;
  logic [WIDTH-1:0] out;

  modport master (
    output enable, in, rank_sel, clear,
    input  busy, overrun, out_enable, out
  );

  modport slave (
    input  enable, in, rank_sel, clear,
    output busy, overrun, out_enable, out
  );
endinterface

// File: rtl/median_filter_param_cmp_swap.sv
// Combinational compare-exchange cell: lo gets the smaller operand, equal operands keep order.
module median_cmp_swap
  import median_filter_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int SIGNED = 0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);
  logic a_le_b;

  assign a_le_b = median_le(32'(a), 32'(b), SIGNED != 0, WIDTH);
  assign lo     = a_le_b ? a : b;
  assign hi     = a_le_b ? b : a;
endmodule

// File: rtl/median_filter_param.sv
// Sliding-window rank filter: snapshot on a full window, DEPTH odd-even transposition
// stages, then min/median/max registered out with a one-cycle strobe.
module median_filter_param
  import median_filter_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 11,
  parameter int SIGNED = 0
) (
  input  logic                  ck100m,
  input  logic                  srst_n,
  median_filter_param_if.slave  bus
);
  localparam int CW = $clog2(DEPTH + 1);

  if (DEPTH % 2 == 0 || DEPTH < 3 || DEPTH > 31) begin : g_bad_depth
    $error("median_filter_param: DEPTH must be odd and within 3..31");
  end
  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("median_filter_param: WIDTH must be within 2..32");
  end

  typedef logic [WIDTH-1:0] word_t;

  // Only DEPTH-1 past samples are stored; the live sample completes the window.
  word_t         win_q  [DEPTH-1];
  word_t         win_d  [DEPTH-1];
  word_t         sort_q [DEPTH];
  word_t         sort_d [DEPTH];
  word_t         even_res [DEPTH];
  word_t         odd_res  [DEPTH];
  logic [CW-1:0] fill_q, fill_d, stage_q, stage_d;
  state_t        state_q, state_d;
  logic [1:0]    rank_q, rank_d;
  logic          overrun_q, overrun_d, oen_q, oen_d;
  word_t         out_q, out_d;
  logic          full;

  for (genvar gi = 0; gi < DEPTH / 2; gi++) begin : g_pairs
    median_cmp_swap #(.WIDTH(WIDTH), .SIGNED(SIGNED)) u_even (
      .a(sort_q[2*gi]), .b(sort_q[2*gi+1]),
      .lo(even_res[2*gi]), .hi(even_res[2*gi+1])
    );
    median_cmp_swap #(.WIDTH(WIDTH), .SIGNED(SIGNED)) u_odd (
      .a(sort_q[2*gi+1]), .b(sort_q[2*gi+2]),
      .lo(odd_res[2*gi+1]), .hi(odd_res[2*gi+2])
    );
  end
  assign even_res[DEPTH-1] = sort_q[DEPTH-1];
  assign odd_res[0]        = sort_q[0];

  assign full = (fill_q >= CW'(DEPTH - 1));

  always_comb begin
    win_d     = win_q;
    sort_d    = sort_q;
    fill_d    = fill_q;
    stage_d   = stage_q;
    state_d   = state_q;
    rank_d    = rank_q;
    overrun_d = 1'b0;
    oen_d     = 1'b0;
    out_d     = out_q;

    if (bus.clear) begin
      for (int i = 0; i < DEPTH - 1; i++) win_d[i] = '0;
      fill_d  = '0;
      state_d = ST_IDLE;
    end else begin
      if (bus.enable) begin
        win_d[0] = bus.in;
        for (int i = 1; i < DEPTH - 1; i++) win_d[i] = win_q[i-1];
        if (fill_q != CW'(DEPTH)) fill_d = fill_q + 1'b1;
      end

      case (state_q)
        ST_IDLE: begin
          if (bus.enable && full) begin
            sort_d[0] = bus.in;
            for (int i = 1; i < DEPTH; i++) sort_d[i] = win_q[i-1];
            rank_d  = bus.rank_sel;
            stage_d = '0;
            state_d = ST_SORT;
          end
        end
        ST_SORT: begin
          overrun_d = bus.enable;
          if (stage_q[0]) sort_d = odd_res;
          else            sort_d = even_res;
          if (stage_q == CW'(DEPTH - 1)) state_d = ST_OUTPUT;
          else                           stage_d = stage_q + 1'b1;
        end
        ST_OUTPUT: begin
          overrun_d = bus.enable;
          case (rank_q)
            RANK_MIN: out_d = sort_q[0];
            RANK_MAX: out_d = sort_q[DEPTH-1];
            default:  out_d = sort_q[DEPTH/2];
          endcase
          oen_d   = 1'b1;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge ck100m or negedge srst_n) begin
    if (!srst_n) begin
      for (int i = 0; i < DEPTH - 1; i++) win_q[i] <= '0;
      for (int i = 0; i < DEPTH; i++) sort_q[i] <= '0;
      fill_q    <= '0;
      stage_q   <= '0;
      state_q   <= ST_IDLE;
      rank_q    <= RANK_MED;
      overrun_q <= 1'b0;
      oen_q     <= 1'b0;
      out_q     <= '0;
    end else begin
      win_q     <= win_d;
      sort_q    <= sort_d;
      fill_q    <= fill_d;
      stage_q   <= stage_d;
      state_q   <= state_d;
      rank_q    <= rank_d;
      overrun_q <= overrun_d;
      oen_q     <= oen_d;
      out_q     <= out_d;
    end
  end

  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.overrun    = overrun_q;
  assign bus.out_enable = oen_q;
  assign bus.out        = out_q;
endmodule

// File: tb/tb_median_filter_param.sv
// Directed bench: 11-tap unsigned filter plus two 3-tap byte filters (signed/unsigned).
module tb_median_filter_param;
  logic ck100m = 1'b0;
  logic srst_n;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 ck100m = ~ck100m;

  median_filter_param_if #(.WIDTH(16)) bus ();
  median_filter_param_if #(.WIDTH(8))  bus_s ();
  median_filter_param_if #(.WIDTH(8))  bus_u ();

  median_filter_param #(.WIDTH(16), .DEPTH(11), .SIGNED(0)) u_dut (
    .ck100m(ck100m), .srst_n(srst_n), .bus(bus)
  );
  median_filter_param #(.WIDTH(8), .DEPTH(3), .SIGNED(1)) u_s8 (
    .ck100m(ck100m), .srst_n(srst_n), .bus(bus_s)
  );
  median_filter_param #(.WIDTH(8), .DEPTH(3), .SIGNED(0)) u_u8 (
    .ck100m(ck100m), .srst_n(srst_n), .bus(bus_u)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Strobe one sample; returns at the falling edge right after the accepting edge.
  task automatic send(input logic [15:0] v, input logic [1:0] rs);
    @(negedge ck100m);
    bus.enable   = 1'b1;
    bus.in       = v;
    bus.rank_sel = rs;
    @(negedge ck100m);
    bus.enable = 1'b0;
  endtask

  // lat = index of the falling edge (1 = first after acceptance) showing out_enable, -1 if none.
  task automatic wait_oen(output int lat, output logic [15:0] val);
    lat = -1;
    val = '0;
    for (int i = 1; i <= 20 && lat < 0; i++) begin
      if (bus.out_enable) begin
        lat = i;
        val = bus.out;
      end else begin
        @(negedge ck100m);
      end
    end
  endtask

  task automatic send8(input logic [7:0] v, input logic [1:0] rs);
    @(negedge ck100m);
    bus_s.enable = 1'b1; bus_s.in = v; bus_s.rank_sel = rs;
    bus_u.enable = 1'b1; bus_u.in = v; bus_u.rank_sel = rs;
    @(negedge ck100m);
    bus_s.enable = 1'b0;
    bus_u.enable = 1'b0;
  endtask

  task automatic wait_oen8(output int lat_s, output logic [7:0] val_s,
                           output int lat_u, output logic [7:0] val_u);
    lat_s = -1; lat_u = -1; val_s = '0; val_u = '0;
    for (int i = 1; i <= 10; i++) begin
      if (bus_s.out_enable && lat_s < 0) begin lat_s = i; val_s = bus_s.out; end
      if (bus_u.out_enable && lat_u < 0) begin lat_u = i; val_u = bus_u.out; end
      @(negedge ck100m);
    end
  endtask

  initial begin
    int          lat, lat_u, cnt, ovr;
    logic [15:0] val;
    logic [7:0]  val_s, val_u;
    logic [15:0] rank_list [11] = '{16'd9, 16'd3, 16'd7, 16'd1, 16'd5, 16'd11,
                                    16'd2, 16'd8, 16'd4, 16'd10, 16'd6};
    logic [1:0]  rank_pass [3] = '{2'd0, 2'd2, 2'd1};
    logic [15:0] rank_exp  [3] = '{16'd1, 16'd11, 16'd6};

    bus.enable = 0;   bus.in = '0;   bus.rank_sel = 2'd1;   bus.clear = 0;
    bus_s.enable = 0; bus_s.in = '0; bus_s.rank_sel = 2'd1; bus_s.clear = 0;
    bus_u.enable = 0; bus_u.in = '0; bus_u.rank_sel = 2'd1; bus_u.clear = 0;
    srst_n = 1'b0;
    repeat (3) @(negedge ck100m);
    srst_n = 1'b1;

    chk("reset_busy", 32'(bus.busy), 0);
    chk("reset_overrun", 32'(bus.overrun), 0);
    chk("reset_oen", 32'(bus.out_enable), 0);
    chk("reset_out", 32'(bus.out), 0);

    // Warm-up: ascending 1..11, only the 11th produces a result.
    for (int k = 1; k <= 11; k++) begin
      send(16'(k), 2'd1);
      wait_oen(lat, val);
      if (k < 11) chk($sformatf("warm_%0d", k), 32'(lat), 32'hFFFF_FFFF);
      else begin
        chk("asc_latency", 32'(lat), 13);
        chk("asc_median", 32'(val), 6);
      end
    end

    // Signed versus unsigned byte compare on the 3-tap instances.
    send8(8'hFB, 2'd1);
    send8(8'h03, 2'd1);
    send8(8'hFF, 2'd1);
    wait_oen8(lat, val_s, lat_u, val_u);
    chk("s8_latency", 32'(lat), 5);
    chk("s8_median", 32'(val_s), 32'hFF);
    chk("u8_latency", 32'(lat_u), 5);
    chk("u8_median", 32'(val_u), 32'hFB);
    send8(8'h80, 2'd0);
    wait_oen8(lat, val_s, lat_u, val_u);
    chk("s8_min", 32'(val_s), 32'h80);
    chk("u8_min", 32'(val_u), 32'h03);

    // Rank select: replay the list so the window ends as the given set.
    for (int p = 0; p < 3; p++) begin
      for (int k = 0; k < 11; k++) begin
        send(rank_list[k], (k == 10) ? rank_pass[p] : 2'd1);
        wait_oen(lat, val);
        if (k == 10) begin
          chk($sformatf("rank%0d_latency", rank_pass[p]), 32'(lat), 13);
          chk($sformatf("rank%0d_value", rank_pass[p]), 32'(val), 32'(rank_exp[p]));
        end
      end
    end

    // Overrun: second strobe 4 cycles after the accepting one.
    send(16'd100, 2'd1);
    ovr = 0; lat = -1; val = '0;
    for (int i = 1; i <= 20; i++) begin
      if (i == 4) begin bus.enable = 1'b1; bus.in = 16'd200; end
      else bus.enable = 1'b0;
      if (bus.overrun) ovr++;
      if (bus.out_enable && lat < 0) begin lat = i; val = bus.out; end
      @(negedge ck100m);
    end
    chk("ovr_pulses", 32'(ovr), 1);
    chk("ovr_latency", 32'(lat), 13);
    chk("ovr_first_snapshot", 32'(val), 6);
    send(16'd300, 2'd1);
    wait_oen(lat, val);
    chk("ovr_next_median", 32'(val), 8);

    // clear mid-sort.
    send(16'd50, 2'd1);
    cnt = 0;
    for (int i = 1; i <= 20; i++) begin
      bus.clear = (i == 4);
      if (i == 5) chk("clr_busy", 32'(bus.busy), 0);
      if (bus.out_enable) cnt++;
      @(negedge ck100m);
    end
    chk("clr_no_oen", 32'(cnt), 0);
    chk("clr_out_held", 32'(bus.out), 8);
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      send(16'(20 + k), 2'd1);
      wait_oen(lat, val);
      if (lat >= 0) cnt++;
    end
    chk("clr_refill_quiet", 32'(cnt), 0);
    send(16'd30, 2'd1);
    wait_oen(lat, val);
    chk("clr_refill_latency", 32'(lat), 13);
    chk("clr_refill_median", 32'(val), 25);

    // Asynchronous reset between edges during a sort.
    send(16'd60, 2'd1);
    repeat (3) @(negedge ck100m);
    #2 srst_n = 1'b0;
    #1;
    chk("arst_out", 32'(bus.out), 0);
    chk("arst_busy", 32'(bus.busy), 0);
    chk("arst_oen", 32'(bus.out_enable), 0);
    chk("arst_overrun", 32'(bus.overrun), 0);
    srst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge ck100m);
      if (bus.out_enable || bus.out != 16'd0) cnt++;
    end
    chk("arst_quiet", 32'(cnt), 0);
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      send(16'(40 + k), 2'd2);
      wait_oen(lat, val);
      if (lat >= 0 || bus.out != 16'd0) cnt++;
    end
    chk("arst_refill_quiet", 32'(cnt), 0);
    send(16'd50, 2'd2);
    wait_oen(lat, val);
    chk("arst_refill_latency", 32'(lat), 13);
    chk("arst_refill_max", 32'(val), 50);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/median_filter_param.md
# median_filter_param

Parametrised successor of the 11-tap, 16-bit median filter. It keeps a sliding window of the last DEPTH accepted samples of configurable width and signedness. On each accepted sample it runs a sequential odd-even transposition sort over a snapshot, then outputs a runtime-selected rank: minimum, median or maximum. Unlike the fixed version, it adds warm-up suppression, a synchronous window flush, a busy indication and an overrun flag.

## Interface
Parameters:
- WIDTH, 16, sample width in bits (2..32)
- DEPTH, 11, window length; must be odd, 3..31 (elaboration assertion)
- SIGNED, 0, 1 = two's-complement compare, 0 = unsigned compare

Ports:
- ck100m  in  1  clock; single clock domain
- srst_n  in  1  reset, asynchronous, active-low
- enable  in  1  sample strobe; `in` is valid in this cycle
- in  in  WIDTH  sample data
- rank_sel  in  2  0 = min, 1 = median, 2 = max, 3 = median
- clear  in  1  synchronous flush of window and fill count
- busy  out  1  high while a sort is in progress (state is not ST_IDLE)
- overrun  out  1  one-cycle pulse: sample accepted while busy, so no result is produced for it
- out_enable  out  1  one-cycle pulse when `out` is updated
- out  out  WIDTH  selected rank, registered

## Operation
- **Reset values:**
  - window, sort array, fill count: 0
  - state: ST_IDLE
  - busy, overrun, out_enable: 0
  - out: 0
- **Window:**
  - On `enable` with `clear` low, in shifts into window[0]; window[i] <= window[i-1].
  - The window updates in every state, busy or not.
- **Fill count:**
  - Saturating counter, 0..DEPTH, incremented on each accepted sample.
  - `full` means fill count plus the current sample is at least DEPTH.
- **State ST_IDLE:**
  - On `enable` with `full` and `clear` low:
    - sort_array[0] <= in; sort_array[i] <= window[i-1], so the snapshot includes the new sample;
    - latch rank_sel;
    - stage counter <= 0;
    - go to ST_SORT.
  - On `enable` when not `full`, only the window and fill count update; no output follows.
- **State ST_SORT:**
  - One compare-exchange stage per cycle.
  - Even stage (counter[0]=0) pairs (0,1),(2,3),…; odd stage pairs (1,2),(3,4),…
  - Each pair writes the lower value to the lower index.
  - Equal values are not swapped.
  - After DEPTH stages (counter reaches DEPTH-1), go to ST_OUTPUT.
- **State ST_OUTPUT:**
  - out <= sort_array[0], [DEPTH/2] or [DEPTH-1] according to the latched rank_sel.
  - out_enable <= 1.
  - Go to ST_IDLE.
- **Overrun:** `enable` in ST_SORT or ST_OUTPUT still shifts the window but starts no sort. overrun pulses in the following cycle.
- **clear:**
  - Window and fill count are zeroed, state goes to ST_IDLE and any in-progress sort is aborted with no out_enable.
  - `out` holds its value.
  - clear has priority over a simultaneous `enable`; that sample is discarded and no overrun is raised.
- **Compare:** through the SIGNED-dependent less-or-equal function. No width growth.

## Timing
- Take cycle 0 as the clock edge that samples `enable` in ST_IDLE with `full`.
  - Edge 0: snapshot loaded; busy is high from edge 0.
  - Edges 1..DEPTH: sort stages.
  - Edge DEPTH+1: ST_OUTPUT registers out and out_enable; the state returns to ST_IDLE and busy drops.
- out_enable and the new `out` are visible in the cycle after edge DEPTH+1. For DEPTH=11 that is 12 edges after the accepting edge.
- The earliest next accepted strobe is at edge DEPTH+2. The sustained throughput is one result per DEPTH+2 cycles.
- The first result needs DEPTH accepted samples after reset or clear.
- Reset assertion mid-sort clears everything immediately; there is no partial output.

## Structure
- **Package median_filter_pkg:**
  - state enum {ST_IDLE, ST_SORT, ST_OUTPUT};
  - rank_sel encodings RANK_MIN, RANK_MED, RANK_MAX;
  - parametrised less-or-equal function (signed/unsigned).
- **Sub-module median_cmp_swap:**
  - parameters WIDTH and SIGNED;
  - inputs a, b; outputs lo, hi;
  - purely combinational, instantiated DEPTH/2 times per stage mux.
- The top level holds the window, the sort array, the counters and the FSM.

## Test plan
- **Median ascending:** DEPTH=11, WIDTH=16, rank_sel=1; after reset, enable with in=1..11 back-to-back spaced 13 cycles. Required response:
  - no out_enable for samples 1..10;
  - after the 11th strobe, out=6 with out_enable exactly 12 edges later.
- **Rank select:** window holds {9,3,7,1,5,11,2,8,4,10,6}. rank_sel=0 gives out=1; rank_sel=2 gives out=11; rank_sel=1 gives out=6.
- **Signed:** SIGNED=1, WIDTH=8, DEPTH=3, input -5,3,-1 gives median -1 (0xFF). SIGNED=0 with the same bytes gives median 0xFB.
- **Overrun:** a full window, then a second `enable` 4 cycles after the accepting strobe. Required response:
  - overrun pulses once;
  - the result reflects the first snapshot only;
  - the next strobe after busy falls includes both samples in the window.
- **clear mid-sort:** assert clear during ST_SORT. Required response:
  - no out_enable;
  - busy is 0 next cycle;
  - out is unchanged;
  - DEPTH new samples are needed before the next result.
- **Async reset mid-sort:** srst_n low for 1 ns between edges. Required response: all outputs are 0 immediately and stay 0 until a new full window is accepted.
